// File: rtl/cpu_core_if.sv
// Instruction/data memory port bundle for cpu_core.
// master = the core, slave = the memories (or a testbench model of them).
interface cpu_core_if;
  logic        i_valid_i;
  logic        i_valid_d;
  logic [31:0] i_data_in_i;
  logic [31:0] i_data_in_d;
  logic [31:0] o_addr_i;
  logic [31:0] o_addr_d;
  logic [3:0]  o_we_d;
  logic        o_rd_d;
  logic [31:0] o_data_out_d;

  modport master (
    input  i_valid_i, i_valid_d, i_data_in_i, i_data_in_d,
    output o_addr_i, o_addr_d, o_we_d, o_rd_d, o_data_out_d
  );

  modport slave (
    output i_valid_i, i_valid_d, i_data_in_i, i_data_in_d,
    input  o_addr_i, o_addr_d, o_we_d, o_rd_d, o_data_out_d
  );
endinterface

// File: rtl/cpu_core.sv
// Multicycle RV32I core: each instruction is fetched in one state and executed in the next.
// state   | meaning
// FETCH   | o_addr_i = pc, latch instruction when i_valid_i
// EXECUTE | decode ir, drive data port, commit rd/pc (waits on i_valid_d for loads/stores)
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        i_clk,
  input logic        i_rst,
  cpu_core_if.master bus
);
  typedef enum logic {FETCH, EXECUTE} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'd0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  // Shared ALU for OP and OP-IMM; ir[30] selects SUB / SRA(I).
  logic [31:0] op_b, alu;
  always_comb begin
    op_b = (opcode == OP_REG) ? rs2_val : imm_i;
    alu  = 32'd0;
    case (f3)
      3'b000: alu = (opcode == OP_REG && ir[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'b001: alu = rs1_val << op_b[4:0];
      3'b010: alu = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011: alu = {31'd0, rs1_val < op_b};
      3'b100: alu = rs1_val ^ op_b;
      3'b101: alu = ir[30] ? $unsigned($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'b110: alu = rs1_val | op_b;
      default: alu = rs1_val & op_b;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = (rs1_val == rs2_val);
      3'b001: taken = (rs1_val != rs2_val);
      3'b100: taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: taken = (rs1_val < rs2_val);
      3'b111: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  logic        is_load, is_store, mem_op;
  logic [31:0] mem_addr;
  logic [1:0]  lane;
  assign is_load  = (opcode == OP_LOAD) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_store = (opcode == OP_STORE) && (f3 inside {3'b000, 3'b001, 3'b010});
  assign mem_op   = is_load || is_store;
  assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
  assign lane     = mem_addr[1:0];

  logic [3:0]  st_we;
  logic [31:0] st_data;
  always_comb begin
    st_we   = 4'b1111;
    st_data = rs2_val;
    case (f3[1:0])
      2'b00: begin
        st_we   = 4'b0001 << lane;
        st_data = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        st_we   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      default: ;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  always_comb begin
    case (lane)
      2'd0:    ld_byte = bus.i_data_in_d[7:0];
      2'd1:    ld_byte = bus.i_data_in_d[15:8];
      2'd2:    ld_byte = bus.i_data_in_d[23:16];
      default: ld_byte = bus.i_data_in_d[31:24];
    endcase
    ld_half = lane[1] ? bus.i_data_in_d[31:16] : bus.i_data_in_d[15:0];
    case (f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = bus.i_data_in_d;
    endcase
  end

  logic        rd_we;
  logic [31:0] rd_val, next_pc;
  always_comb begin
    rd_we   = 1'b0;
    rd_val  = alu;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL:    begin rd_we = 1'b1; rd_val = pc_plus4; next_pc = pc + imm_j; end
      OP_JALR:   begin rd_we = 1'b1; rd_val = pc_plus4; next_pc = (rs1_val + imm_i) & ~32'd1; end
      OP_BRANCH: if (taken) next_pc = pc + imm_b;
      OP_LOAD:   begin rd_we = is_load; rd_val = ld_val; end
      OP_IMM, OP_REG: rd_we = 1'b1;
      default: ;
    endcase
  end

  // Data-port strobes exist only in EXECUTE, so reset (state <- FETCH) silences them at once.
  logic in_exec;
  assign in_exec          = (state == EXECUTE);
  assign bus.o_addr_i     = pc;
  assign bus.o_addr_d     = (in_exec && mem_op) ? mem_addr : 32'd0;
  assign bus.o_we_d       = (in_exec && is_store) ? st_we : 4'd0;
  assign bus.o_rd_d       = in_exec && is_load;
  assign bus.o_data_out_d = (in_exec && is_store) ? st_data : 32'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc    <= RESET_PC;
      state <= FETCH;
    end else begin
      case (state)
        FETCH: if (bus.i_valid_i) begin
          ir    <= bus.i_data_in_i;
          state <= EXECUTE;
        end
        default: if (!mem_op || bus.i_valid_d) begin
          if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
          pc    <= next_pc;
          state <= FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_core.sv
// Directed programs for cpu_core; a monitor checks the fetch-address trace and data-port transactions
// against a queue of hand-computed expected events.
module tb_cpu_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cpu_core_if bus();

  cpu_core #(.RESET_PC(32'h0000_0000)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ev  = 0;
  logic [31:0] imem [logic [31:0]];
  logic        mon_en = 1'b0;
  logic [31:0] last_i = 32'd0;

  logic        arm_i = 1'b0, act_i = 1'b0, arm_d = 1'b0, act_d = 1'b0;
  logic [31:0] stall_i_addr = 32'hFFFF_FFFF;
  int          left_i = 0, left_d = 0, len_i = 3, len_d = 2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd, op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h0000_0013;
  endfunction
  function automatic logic [31:0] dmem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w == 32'h100) ? 32'hF000_0000 : 32'h0;
  endfunction

  task automatic ef(input logic [31:0] a);
    exp_q.push_back({2'd0, a, 4'd0, 32'd0});
  endtask
  task automatic el(input logic [31:0] a);
    exp_q.push_back({2'd1, a, 4'd0, 32'd0});
  endtask
  task automatic es(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    exp_q.push_back({2'd2, a, we, d});
  endtask

  task automatic got_ev(input ev_t g);
    ev_t e;
    n_cmp++;
    n_ev++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event#%0d: got kind=%0d addr=%h we=%b data=%h, want none",
               n_ev, g.kind, g.addr, g.we, g.data);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_bad++;
        $display("FAIL event#%0d: got kind=%0d addr=%h we=%b data=%h, want kind=%0d addr=%h we=%b data=%h",
                 n_ev, g.kind, g.addr, g.we, g.data, e.kind, e.addr, e.we, e.data);
      end
    end
  endtask

  // Monitor: a new o_addr_i is a new fetch; a strobe with i_valid_d high is an accepted transfer.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (bus.o_addr_i !== last_i) begin
        last_i = bus.o_addr_i;
        got_ev({2'd0, bus.o_addr_i, 4'd0, 32'd0});
      end
      if (bus.o_we_d != 4'd0 || bus.o_rd_d) begin
        check("strobe_exclusive", {31'd0, (bus.o_we_d != 4'd0) && bus.o_rd_d}, 32'd0);
        if (bus.i_valid_d) begin
          if (bus.o_rd_d) got_ev({2'd1, bus.o_addr_d, 4'd0, 32'd0});
          else            got_ev({2'd2, bus.o_addr_d, bus.o_we_d, bus.o_data_out_d});
        end
      end
    end
  end

  // Memory model and stall driver; runs at posedge+2 so it never races the stimulus at posedge+1.
  initial begin
    bus.i_valid_i   = 1'b1;
    bus.i_valid_d   = 1'b1;
    bus.i_data_in_i = 32'd0;
    bus.i_data_in_d = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bus.i_valid_i = 1'b1;
        bus.i_valid_d = 1'b1;
        act_i = 1'b0;
        act_d = 1'b0;
      end else begin
        if (act_i) begin
          check("fetch_stall_addr", bus.o_addr_i, stall_i_addr);
          if (left_i == 0) begin bus.i_valid_i = 1'b1; act_i = 1'b0; end
          else begin bus.i_valid_i = 1'b0; left_i--; end
        end else if (arm_i && bus.o_addr_i == stall_i_addr) begin
          arm_i = 1'b0; act_i = 1'b1; bus.i_valid_i = 1'b0; left_i = len_i - 1;
        end
        if (act_d) begin
          check("store_stall_we", {28'd0, bus.o_we_d}, 32'hF);
          if (left_d == 0) begin bus.i_valid_d = 1'b1; act_d = 1'b0; end
          else begin bus.i_valid_d = 1'b0; left_d--; end
        end else if (arm_d && (bus.o_we_d != 4'd0 || bus.o_rd_d)) begin
          arm_d = 1'b0; act_d = 1'b1; bus.i_valid_d = 1'b0; left_d = len_d - 1;
        end
      end
      bus.i_data_in_i = imem_rd(bus.o_addr_i);
      bus.i_data_in_d = dmem_rd(bus.o_addr_d);
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("rst_addr_i", bus.o_addr_i, 32'h0);
      check("rst_we_d", {28'd0, bus.o_we_d}, 32'h0);
      check("rst_rd_d", {31'd0, bus.o_rd_d}, 32'h0);
      check("rst_addr_d", bus.o_addr_d, 32'h0);
      check("rst_data_out_d", bus.o_data_out_d, 32'h0);
    end
    rst = 1'b0;
    check("first_fetch_addr", bus.o_addr_i, 32'h0);
    last_i = 32'h0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    mon_en = 1'b0;
    #1;
    check({name, "_leftover_events"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Straight-line arithmetic and a word store.
    imem.delete();
    imem[32'h0] = enc_i(5, 0, 0, 1, 7'h13);
    imem[32'h4] = enc_i(-7, 1, 0, 2, 7'h13);
    imem[32'h8] = enc_s(32'h100, 2, 0, 2);
    ef(32'h4); ef(32'h8); es(32'h100, 4'b1111, 32'hFFFF_FFFE); ef(32'hC);
    do_reset();
    @(posedge clk); #1;
    check("fetch_hold_exec", bus.o_addr_i, 32'h0);
    @(posedge clk); #1;
    check("second_fetch_addr", bus.o_addr_i, 32'h4);
    drain("prog_arith");

    // Byte and halfword lanes for stores and loads.
    imem.delete();
    imem[32'h00] = enc_u(32'h12345, 3, 7'h37);
    imem[32'h04] = enc_i(32'h678, 3, 0, 3, 7'h13);
    imem[32'h08] = enc_s(32'h103, 3, 0, 0);
    imem[32'h0C] = enc_i(32'h103, 0, 0, 4, 7'h03);
    imem[32'h10] = enc_i(32'h103, 0, 4, 5, 7'h03);
    imem[32'h14] = enc_s(32'h200, 4, 0, 2);
    imem[32'h18] = enc_s(32'h204, 5, 0, 2);
    imem[32'h1C] = enc_s(32'h102, 3, 0, 1);
    imem[32'h20] = enc_i(32'h102, 0, 1, 6, 7'h03);
    imem[32'h24] = enc_s(32'h208, 6, 0, 2);
    ef(32'h04); ef(32'h08); es(32'h103, 4'b1000, 32'h7878_7878);
    ef(32'h0C); el(32'h103); ef(32'h10); el(32'h103);
    ef(32'h14); es(32'h200, 4'b1111, 32'hFFFF_FFF0);
    ef(32'h18); es(32'h204, 4'b1111, 32'h0000_00F0);
    ef(32'h1C); es(32'h102, 4'b1100, 32'h5678_5678);
    ef(32'h20); el(32'h102); ef(32'h24); es(32'h208, 4'b1111, 32'hFFFF_F000); ef(32'h28);
    do_reset();
    drain("prog_lanes");

    // Branches, JAL to a far target and a two-iteration backward loop.
    imem.delete();
    imem[32'h00]    = enc_b(8, 0, 0, 1);
    imem[32'h04]    = enc_j(32'h1C, 0);
    imem[32'h20]    = enc_j(32'h10000, 1);
    imem[32'h10020] = enc_s(32'h300, 1, 0, 2);
    imem[32'h10024] = enc_b(-4, 0, 0, 0);
    ef(32'h4); ef(32'h20); ef(32'h10020);
    es(32'h300, 4'b1111, 32'h24); ef(32'h10024); ef(32'h10020);
    es(32'h300, 4'b1111, 32'h24); ef(32'h10024); ef(32'h10020);
    do_reset();
    drain("prog_flow");

    // Fetch stall (3 cycles at 0x8) and store stall (2 cycles on the first SW).
    imem.delete();
    imem[32'h0] = enc_i(32'h55, 0, 0, 1, 7'h13);
    imem[32'h4] = enc_s(32'h40, 1, 0, 2);
    imem[32'h8] = enc_i(1, 1, 0, 2, 7'h13);
    imem[32'hC] = enc_s(32'h44, 2, 0, 2);
    ef(32'h4); es(32'h40, 4'b1111, 32'h55); ef(32'h8); ef(32'hC);
    es(32'h44, 4'b1111, 32'h56); ef(32'h10);
    stall_i_addr = 32'h8; len_i = 3; arm_i = 1'b1;
    len_d = 2; arm_d = 1'b1;
    do_reset();
    drain("prog_stall");
    check("fetch_stall_done", {31'd0, arm_i | act_i}, 32'd0);
    check("data_stall_done", {31'd0, arm_d | act_d}, 32'd0);

    // Shifts, compares, SUB, unsigned branch, x0 discard and JALR with LSB cleared.
    imem.delete();
    imem[32'h00]    = enc_u(32'h10, 5, 7'h37);
    imem[32'h04]    = enc_i(1, 0, 0, 0, 7'h13);
    imem[32'h08]    = enc_s(32'h50, 0, 0, 2);
    imem[32'h0C]    = enc_i(-3, 0, 0, 6, 7'h13);
    imem[32'h10]    = enc_i(32'h401, 6, 5, 9, 7'h13);
    imem[32'h14]    = enc_s(32'h54, 9, 0, 2);
    imem[32'h18]    = enc_i(28, 6, 5, 10, 7'h13);
    imem[32'h1C]    = enc_s(32'h58, 10, 0, 2);
    imem[32'h20]    = enc_r(0, 6, 0, 3, 11);
    imem[32'h24]    = enc_r(0, 6, 0, 2, 12);
    imem[32'h28]    = enc_r(32'h20, 6, 11, 0, 13);
    imem[32'h2C]    = enc_s(32'h5C, 13, 0, 2);
    imem[32'h30]    = enc_s(32'h60, 12, 0, 2);
    imem[32'h34]    = enc_b(8, 5, 6, 6);
    imem[32'h38]    = enc_i(1, 5, 0, 0, 7'h67);
    imem[32'h10000] = enc_s(32'h64, 5, 0, 2);
    ef(32'h04); ef(32'h08); es(32'h50, 4'b1111, 32'h0);
    ef(32'h0C); ef(32'h10); ef(32'h14); es(32'h54, 4'b1111, 32'hFFFF_FFFE);
    ef(32'h18); ef(32'h1C); es(32'h58, 4'b1111, 32'hF);
    ef(32'h20); ef(32'h24); ef(32'h28); ef(32'h2C); es(32'h5C, 4'b1111, 32'h4);
    ef(32'h30); es(32'h60, 4'b1111, 32'h0);
    ef(32'h34); ef(32'h38); ef(32'h10000); es(32'h64, 4'b1111, 32'h10000); ef(32'h10004);
    do_reset();
    drain("prog_alu");

    // Reset in the middle of a stalled store must drop the strobe at the reset edge.
    imem.delete();
    imem[32'h0] = enc_s(32'h70, 0, 0, 2);
    len_d = 20; arm_d = 1'b1;
    do_reset();
    mon_en = 1'b0;
    begin
      int cyc = 0;
      while (bus.o_we_d == 4'd0 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("midinst_we_asserted", {28'd0, bus.o_we_d}, 32'hF);
    repeat (3) @(posedge clk);
    #1;
    check("midinst_we_held", {28'd0, bus.o_we_d}, 32'hF);
    check("midinst_addr_d", bus.o_addr_d, 32'h70);
    do_reset();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
